// File: rtl/npu_pkg.sv
// Shared definitions for the NPU result reader: widths and the reader FSM state encoding.
package npu_pkg;

  localparam int NPU_BYTE_W = 8;
  localparam int NPU_RES_W  = 16;
  localparam int NPU_IDX_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_HI,
    ST_WAIT_HI,
    ST_FETCH_LO,
    ST_WAIT_LO,
    ST_PRESENT,
    ST_DONE
  } reader_state_t;

endpackage

// File: rtl/npu_argmax_tracker.sv
// Running signed maximum over the words of one frame; the first loaded word always wins,
// later words replace it only when strictly greater.
module npu_argmax_tracker
  import npu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [NPU_RES_W-1:0] data,
  input  logic [NPU_IDX_W-1:0] idx,
  output logic [NPU_RES_W-1:0] max_val,
  output logic [NPU_IDX_W-1:0] max_idx
);

  logic first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      max_idx <= '0;
      first   <= 1'b1;
    end else if (clear) begin
      max_val <= '0;
      max_idx <= '0;
      first   <= 1'b1;
    end else if (load) begin
      first <= 1'b0;
      if (first || ($signed(data) > $signed(max_val))) begin
        max_val <= data;
        max_idx <= idx;
      end
    end
  end

endmodule

// File: rtl/npu_result_reader.sv
// Drains NPU output FIFO byte pairs into 16-bit results (high byte first) over valid/ready.
// Optional argmax tracking is enabled by defining NPU_READER_ARGMAX_EN.
module npu_result_reader
  import npu_pkg::*;
#(
  parameter int NUM_RESULTS = 4
) (
  input  logic                  CLKEXT,
  input  logic                  RST_GLO_N,
  input  logic                  START,
  input  logic                  EMPTY,
  input  logic [NPU_BYTE_W-1:0] FIFO_DATA,
  output logic                  RD_EN,
  output logic [NPU_RES_W-1:0]  RES_DATA,
  output logic [NPU_IDX_W-1:0]  RES_IDX,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic                  RES_LAST,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic [NPU_IDX_W-1:0]  ARGMAX_IDX,
  output logic [NPU_RES_W-1:0]  ARGMAX_VAL
);

  reader_state_t         state, next_state;
  logic [NPU_IDX_W-1:0]  cnt;
  logic [NPU_BYTE_W-1:0] hi_reg, lo_reg;
  logic                  busy_reg;
  logic                  start_frame, accept;

  assign start_frame = (state == ST_IDLE) && START;
  assign accept      = (state == ST_PRESENT) && RES_READY;

  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:     if (START)  next_state = ST_FETCH_HI;
      ST_FETCH_HI: if (!EMPTY) next_state = ST_WAIT_HI;
      ST_WAIT_HI:              next_state = ST_FETCH_LO;
      ST_FETCH_LO: if (!EMPTY) next_state = ST_WAIT_LO;
      ST_WAIT_LO:              next_state = ST_PRESENT;
      ST_PRESENT:  if (RES_READY) next_state = (cnt == '0) ? ST_DONE : ST_FETCH_HI;
      ST_DONE:                 next_state = ST_IDLE;
      default:                 next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    RD_EN      = 1'b0;
    RES_VALID  = 1'b0;
    RES_LAST   = 1'b0;
    FRAME_DONE = 1'b0;
    unique case (state)
      ST_FETCH_HI, ST_FETCH_LO: RD_EN = !EMPTY;
      ST_PRESENT: begin
        RES_VALID = 1'b1;
        RES_LAST  = (cnt == '0);
      end
      ST_DONE:    FRAME_DONE = 1'b1;
      default:    ;
    endcase
  end

  // FIFO data is valid the cycle after the pop, which is exactly the WAIT_* state.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      cnt      <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      busy_reg <= 1'b0;
    end else begin
      if (start_frame)                cnt <= NPU_IDX_W'(NUM_RESULTS - 1);
      else if (accept && cnt != '0)   cnt <= cnt - 1'b1;
      if (state == ST_WAIT_HI) hi_reg <= FIFO_DATA;
      if (state == ST_WAIT_LO) lo_reg <= FIFO_DATA;
      if (start_frame)            busy_reg <= 1'b1;
      else if (state == ST_DONE)  busy_reg <= 1'b0;
    end
  end

  assign RES_DATA = {hi_reg, lo_reg};
  assign RES_IDX  = cnt;
  assign BUSY     = busy_reg;

`ifdef NPU_READER_ARGMAX_EN
  npu_argmax_tracker u_argmax (
    .clk     (CLKEXT),
    .rst_n   (RST_GLO_N),
    .clear   (start_frame),
    .load    (accept),
    .data    (RES_DATA),
    .idx     (cnt),
    .max_val (ARGMAX_VAL),
    .max_idx (ARGMAX_IDX)
  );
`else
  assign ARGMAX_IDX = '0;
  assign ARGMAX_VAL = '0;
`endif

endmodule

// File: tb/tb_npu_result_reader.sv
// Self-checking bench for npu_result_reader: FIFO model, random/directed frames, reference scoreboard.
module tb_npu_result_reader;

  localparam int NUM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, empty, rd_en, res_valid, res_ready, res_last, busy, frame_done;
  logic [7:0]  fifo_data;
  logic [15:0] res_data, argmax_val;
  logic [3:0]  res_idx, argmax_idx;

  npu_result_reader #(.NUM_RESULTS(NUM)) dut (
    .CLKEXT(clk), .RST_GLO_N(rst_n), .START(start), .EMPTY(empty), .FIFO_DATA(fifo_data),
    .RD_EN(rd_en), .RES_DATA(res_data), .RES_IDX(res_idx), .RES_VALID(res_valid),
    .RES_READY(res_ready), .RES_LAST(res_last), .BUSY(busy), .FRAME_DONE(frame_done),
    .ARGMAX_IDX(argmax_idx), .ARGMAX_VAL(argmax_val)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  // FIFO model: bytes pushed by the stimulus, popped one cycle before they appear on D_OUT.
  logic [7:0] mem [0:255];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pop_count = 0;
  logic stall = 1'b0;
  logic fifo_clear = 1'b0;
  logic prev_rd = 1'b0;

  assign empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en) begin
      checkOutput("pop_on_empty", {31'd0, empty}, 32'd0);
      checkOutput("back_to_back_pop", {31'd0, prev_rd}, 32'd0);
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
    prev_rd <= rd_en;
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  logic [15:0] exp_words [0:NUM-1];
  int          exp_amax_idx;
  logic [15:0] exp_amax_val;

  // Reference argmax: scan lanes in arrival order, first loads, strictly-greater replaces.
  task automatic compute_argmax();
    bit first = 1'b1;
    exp_amax_idx = 0;
    exp_amax_val = '0;
`ifdef NPU_READER_ARGMAX_EN
    for (int lane = NUM - 1; lane >= 0; lane--) begin
      if (first || $signed(exp_words[lane]) > $signed(exp_amax_val)) begin
        exp_amax_val = exp_words[lane];
        exp_amax_idx = lane;
      end
      first = 1'b0;
    end
`endif
  endtask

  task automatic check_reset_state();
    checkOutput("rst_rd_en",      {31'd0, rd_en},      0);
    checkOutput("rst_res_valid",  {31'd0, res_valid},  0);
    checkOutput("rst_res_last",   {31'd0, res_last},   0);
    checkOutput("rst_busy",       {31'd0, busy},       0);
    checkOutput("rst_frame_done", {31'd0, frame_done}, 0);
    checkOutput("rst_res_data",   {16'd0, res_data},   0);
    checkOutput("rst_res_idx",    {28'd0, res_idx},    0);
    checkOutput("rst_argmax_idx", {28'd0, argmax_idx}, 0);
    checkOutput("rst_argmax_val", {16'd0, argmax_val}, 0);
  endtask

  // Runs one frame of exp_words through the DUT and scores every cycle.
  task automatic applyStimulus(input int ready_stall_word, input int ready_stall_len,
                               input int starve_len, input int busy_start_cycle,
                               input bit check_timing);
    int  cycle = 0, exp_lane = NUM - 1, word_k = 0, base_pops;
    int  done_cycle = -1, done_count = 0, starve_cnt = 0, ready_cnt = 0;
    bit  done_seen = 1'b0, word_first = 1'b1;
    for (int lane = NUM - 1; lane >= 0; lane--) begin
      push_byte(exp_words[lane][15:8]);
      push_byte(exp_words[lane][7:0]);
    end
    compute_argmax();
    base_pops = pop_count;
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    while (cycle < 400 && !(done_seen && cycle >= done_cycle + 2)) begin
      @(negedge clk);
      cycle++;
      start = (cycle == busy_start_cycle);
      if (starve_len > 0 && (pop_count - base_pops) == 3 && starve_cnt < starve_len) begin
        stall = 1'b1;
        starve_cnt++;
      end else begin
        stall = 1'b0;
      end
      #1;
      if (stall) checkOutput("rd_en_while_empty", {31'd0, rd_en}, 0);
      res_ready = 1'($urandom_range(0, 1));
      if (res_valid) begin
        if (exp_lane < 0) begin
          checkOutput("extra_word", 1, 0);
        end else begin
          checkOutput("res_data", {16'd0, res_data}, {16'd0, exp_words[exp_lane]});
          checkOutput("res_idx", {28'd0, res_idx}, exp_lane);
          checkOutput("res_last", {31'd0, res_last}, {31'd0, exp_lane == 0});
          checkOutput("busy_in_frame", {31'd0, busy}, 1);
          checkOutput("rd_en_in_present", {31'd0, rd_en}, 0);
          if (check_timing && word_first)
            checkOutput("valid_cycle", cycle, 5 * (NUM - 1 - exp_lane) + 5);
          word_first = 1'b0;
          if (word_k == ready_stall_word && ready_cnt < ready_stall_len) begin
            res_ready = 1'b0;
            ready_cnt++;
          end else begin
            res_ready = 1'b1;
            exp_lane--;
            word_k++;
            word_first = 1'b1;
          end
        end
      end
      if (frame_done) begin
        done_count++;
        if (!done_seen) begin
          done_seen  = 1'b1;
          done_cycle = cycle;
          checkOutput("words_before_done", word_k, NUM);
          checkOutput("busy_at_done", {31'd0, busy}, 1);
          checkOutput("argmax_idx", {28'd0, argmax_idx}, exp_amax_idx);
          checkOutput("argmax_val", {16'd0, argmax_val}, {16'd0, exp_amax_val});
          if (check_timing) checkOutput("done_cycle", cycle, 5 * NUM + 1);
        end
      end
      if (done_seen && cycle == done_cycle + 1) begin
        checkOutput("busy_after_done", {31'd0, busy}, 0);
        checkOutput("argmax_held", {12'd0, argmax_idx, argmax_val},
                    {12'd0, 4'(exp_amax_idx), exp_amax_val});
      end
    end
    if (!done_seen) checkOutput("frame_timeout", 0, 1);
    checkOutput("frame_done_pulses", done_count, 1);
    checkOutput("pops_per_frame", pop_count - base_pops, 2 * NUM);
    stall = 1'b0;
    start = 1'b0;
  endtask

  task automatic random_words();
    for (int i = 0; i < NUM; i++) exp_words[i] = 16'($urandom);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frame from the byte stream 00 05 FF F0 01 00 00 7F.
    exp_words[3] = 16'h0005; exp_words[2] = 16'hFFF0;
    exp_words[1] = 16'h0100; exp_words[0] = 16'h007F;
    applyStimulus(-1, 0, 0, -1, 1'b1);

    random_words();
    applyStimulus(-1, 0, 10, -1, 1'b0);

    random_words();
    applyStimulus(1, 4, 0, -1, 1'b0);

    exp_words[3] = 16'h0010; exp_words[2] = 16'h0010;
    exp_words[1] = 16'h8000; exp_words[0] = 16'h0001;
    applyStimulus(-1, 0, 0, -1, 1'b1);

    random_words();
    applyStimulus(-1, 0, 0, 7, 1'b1);

    // Reset during WAIT_LO of the first word, then a clean restart.
    random_words();
    for (int lane = NUM - 1; lane >= 0; lane--) begin
      push_byte(exp_words[lane][15:8]);
      push_byte(exp_words[lane][7:0]);
    end
    base = pop_count;
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("pops_before_reset", pop_count - base, 2);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    fifo_clear = 1'b1;
    @(negedge clk);
    fifo_clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    random_words();
    applyStimulus(-1, 0, 0, -1, 1'b1);

    for (int n = 0; n < 6; n++) begin
      random_words();
      applyStimulus(int'($urandom_range(0, NUM - 1)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 6)), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
